// File: rtl/siso_frame_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | siso_frame_ctrl_if : load handshake and serial bit stream bundle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface siso_frame_ctrl_if #(
  parameter int WIDTH = 8
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             msb_first;
  logic             serial_out;
  logic             bit_valid;
  logic             serial_ready;
  logic [IDX_W-1:0] bit_index;
  logic             frame_done;
  logic             busy;

  modport master (
    output load_valid, load_data, msb_first, serial_ready,
    input  load_ready, serial_out, bit_valid, bit_index, frame_done, busy
  );

  modport slave (
    input  load_valid, load_data, msb_first, serial_ready,
    output load_ready, serial_out, bit_valid, bit_index, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/siso_frame_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | siso_frame_ctrl : word-in, bit-serial-out frame sequencer        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module siso_frame_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  siso_frame_ctrl_if.slave bus
);
  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [WIDTH-1:0] data_rev;

  // MSB-first words are stored reversed so the shifter always drains from bit 0
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign data_rev[i] = bus.load_data[WIDTH-1-i];
  end

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          sreg_d    = bus.msb_first ? data_rev : bus.load_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.serial_ready) begin
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          if (bit_cnt_q == LAST_IDX) begin
            bit_cnt_d    = '0;
            gap_cnt_d    = 8'd0;
            frame_done_d = 1'b1;
            state_d      = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 8'd0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.load_ready = (state_q == ST_IDLE);
  assign bus.bit_valid  = (state_q == ST_SHIFT);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.serial_out = sreg_q[0];
  assign bus.bit_index  = bit_cnt_q;
  assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_siso_frame_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_siso_frame_ctrl : directed bench for siso_frame_ctrl          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_siso_frame_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  siso_frame_ctrl_if #(.WIDTH(8)) b1 ();
  siso_frame_ctrl_if #(.WIDTH(4)) b2 ();

  siso_frame_ctrl #(.WIDTH(8), .GAP_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(b1.slave));
  siso_frame_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (b1.load_ready !== 1'b1) $display("FAIL rst_load_ready got %b want 1", b1.load_ready); else n_pass++;
    n_checks++; if (b1.bit_valid !== 1'b0) $display("FAIL rst_bit_valid got %b want 0", b1.bit_valid); else n_pass++;
    n_checks++; if (b1.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", b1.busy); else n_pass++;
    n_checks++; if (b1.serial_out !== 1'b0) $display("FAIL rst_serial_out got %b want 0", b1.serial_out); else n_pass++;
    n_checks++; if (b1.bit_index !== 3'd0) $display("FAIL rst_bit_index got %0d want 0", b1.bit_index); else n_pass++;
    n_checks++; if (b1.frame_done !== 1'b0) $display("FAIL rst_frame_done got %b want 0", b1.frame_done); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (b1.load_ready !== 1'b1 || b1.busy !== 1'b0) $display("FAIL post_rst_idle ready=%b busy=%b want 1/0", b1.load_ready, b1.busy); else n_pass++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'hB2;  // transmit order bit i = 0,1,0,0,1,1,0,1
    b1.load_data = 8'hB2; b1.msb_first = 1'b0; b1.load_valid = 1'b1;
    tick();
    b1.load_valid = 1'b0; b1.load_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (b1.bit_valid !== 1'b1) $display("FAIL lsb_valid%0d got %b want 1", i, b1.bit_valid); else n_pass++;
      n_checks++; if (b1.serial_out !== exp_bits[i]) $display("FAIL lsb_bit%0d got %b want %b", i, b1.serial_out, exp_bits[i]); else n_pass++;
      n_checks++; if (b1.bit_index !== 3'(i)) $display("FAIL lsb_index%0d got %0d want %0d", i, b1.bit_index, i); else n_pass++;
      n_checks++; if (b1.frame_done !== 1'b0) $display("FAIL lsb_early_done%0d got %b want 0", i, b1.frame_done); else n_pass++;
      tick();
    end
    n_checks++; if (b1.frame_done !== 1'b1) $display("FAIL lsb_done got %b want 1", b1.frame_done); else n_pass++;
    n_checks++; if (b1.load_ready !== 1'b0 || b1.busy !== 1'b1) $display("FAIL lsb_gap1 ready=%b busy=%b want 0/1", b1.load_ready, b1.busy); else n_pass++;
    n_checks++; if (b1.serial_out !== 1'b0 || b1.bit_valid !== 1'b0) $display("FAIL lsb_gap1_out so=%b bv=%b want 0/0", b1.serial_out, b1.bit_valid); else n_pass++;
    tick();
    n_checks++; if (b1.frame_done !== 1'b0) $display("FAIL lsb_done_width got %b want 0", b1.frame_done); else n_pass++;
    n_checks++; if (b1.load_ready !== 1'b0 || b1.busy !== 1'b1) $display("FAIL lsb_gap2 ready=%b busy=%b want 0/1", b1.load_ready, b1.busy); else n_pass++;
    tick();
    n_checks++; if (b1.load_ready !== 1'b1 || b1.busy !== 1'b0) $display("FAIL lsb_idle ready=%b busy=%b want 1/0", b1.load_ready, b1.busy); else n_pass++;
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'h4D;  // transmit order 1,0,1,1,0,0,1,0
    b1.load_data = 8'hB2; b1.msb_first = 1'b1; b1.load_valid = 1'b1;
    tick();
    b1.load_valid = 1'b0; b1.msb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (b1.serial_out !== exp_bits[i] || b1.bit_valid !== 1'b1) $display("FAIL msb_bit%0d got %b/%b want %b/1", i, b1.serial_out, b1.bit_valid, exp_bits[i]); else n_pass++;
      tick();
    end
    n_checks++; if (b1.frame_done !== 1'b1) $display("FAIL msb_done got %b want 1", b1.frame_done); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_stall();
    logic [7:0] exp_bits;
    int k;
    exp_bits = 8'hA5;  // transmit order 1,0,1,0,0,1,0,1
    k = 0;
    b1.load_data = 8'hA5; b1.msb_first = 1'b0; b1.load_valid = 1'b1;
    tick();
    b1.load_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      b1.serial_ready = !(c >= 2 && c < 5);
      n_checks++; if (b1.bit_valid !== 1'b1) $display("FAIL stall_valid_c%0d got %b want 1", c, b1.bit_valid); else n_pass++;
      n_checks++; if (b1.serial_out !== exp_bits[k]) $display("FAIL stall_bit_c%0d got %b want %b", c, b1.serial_out, exp_bits[k]); else n_pass++;
      n_checks++; if (b1.bit_index !== 3'(k)) $display("FAIL stall_index_c%0d got %0d want %0d", c, b1.bit_index, k); else n_pass++;
      if (b1.serial_ready) k++;
      tick();
    end
    b1.serial_ready = 1'b1;
    n_checks++; if (b1.frame_done !== 1'b1 || b1.bit_valid !== 1'b0) $display("FAIL stall_end done=%b bv=%b want 1/0", b1.frame_done, b1.bit_valid); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int first_acc, second_acc, n_acc, viol;
    first_acc = -1; second_acc = -1; n_acc = 0; viol = 0;
    b1.load_data = 8'h0F; b1.msb_first = 1'b0; b1.load_valid = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (b1.busy && b1.load_ready) viol++;
      if (b1.load_valid && b1.load_ready) begin
        n_acc++;
        if (first_acc < 0) first_acc = n;
        else if (second_acc < 0) second_acc = n;
      end
      if (n == 1) begin
        n_checks++; if (b1.serial_out !== 1'b1) $display("FAIL b2b_first_bit got %b want 1", b1.serial_out); else n_pass++;
      end
      if (n == 12) begin
        n_checks++; if (b1.serial_out !== 1'b0 || b1.bit_index !== 3'd0 || b1.bit_valid !== 1'b1) $display("FAIL b2b_second_start so=%b idx=%0d bv=%b want 0/0/1", b1.serial_out, b1.bit_index, b1.bit_valid); else n_pass++;
      end
      tick();
      if (n_acc == 1) b1.load_data = 8'hF0;
      if (n_acc == 2) b1.load_valid = 1'b0;
    end
    n_checks++; if (first_acc !== 0) $display("FAIL b2b_first_acc got %0d want 0", first_acc); else n_pass++;
    n_checks++; if (second_acc !== 11) $display("FAIL b2b_spacing got %0d want 11", second_acc); else n_pass++;
    n_checks++; if (n_acc !== 2) $display("FAIL b2b_accepts got %0d want 2", n_acc); else n_pass++;
    n_checks++; if (viol !== 0) $display("FAIL b2b_ready_while_busy got %0d want 0", viol); else n_pass++;
    for (int w = 0; w < 30 && b1.busy; w++) tick();
    n_checks++; if (b1.busy !== 1'b0) $display("FAIL b2b_drain_timeout busy=%b want 0", b1.busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_bits;
    exp_bits = 8'h6A;  // transmit order 0,1,0,1,0,1,1,0
    b1.load_data = 8'h3C; b1.msb_first = 1'b0; b1.load_valid = 1'b1;
    tick();
    b1.load_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (b1.bit_index !== 3'd4) $display("FAIL rmid_pre_index got %0d want 4", b1.bit_index); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (b1.bit_valid !== 1'b0 || b1.busy !== 1'b0 || b1.load_ready !== 1'b1) $display("FAIL rmid_async bv=%b busy=%b rdy=%b want 0/0/1", b1.bit_valid, b1.busy, b1.load_ready); else n_pass++;
    n_checks++; if (b1.bit_index !== 3'd0 || b1.serial_out !== 1'b0 || b1.frame_done !== 1'b0) $display("FAIL rmid_async_out idx=%0d so=%b fd=%b want 0/0/0", b1.bit_index, b1.serial_out, b1.frame_done); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (b1.frame_done !== 1'b0 || b1.busy !== 1'b0) $display("FAIL rmid_quiet%0d fd=%b busy=%b want 0/0", c, b1.frame_done, b1.busy); else n_pass++;
    end
    b1.load_data = 8'h6A; b1.load_valid = 1'b1;
    tick();
    b1.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (b1.serial_out !== exp_bits[i] || b1.bit_index !== 3'(i)) $display("FAIL rmid_bit%0d got %b/%0d want %b/%0d", i, b1.serial_out, b1.bit_index, exp_bits[i], i); else n_pass++;
      tick();
    end
    n_checks++; if (b1.frame_done !== 1'b1) $display("FAIL rmid_done got %b want 1", b1.frame_done); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_gap0();
    logic [3:0] exp_bits;
    exp_bits = 4'h9;  // transmit order 1,0,0,1
    b2.load_data = 4'h9; b2.msb_first = 1'b0; b2.load_valid = 1'b1;
    tick();
    b2.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (b2.serial_out !== exp_bits[i] || b2.bit_index !== 2'(i) || b2.bit_valid !== 1'b1) $display("FAIL g0_bit%0d got %b/%0d/%b want %b/%0d/1", i, b2.serial_out, b2.bit_index, b2.bit_valid, exp_bits[i], i); else n_pass++;
      tick();
    end
    n_checks++; if (b2.frame_done !== 1'b1) $display("FAIL g0_done got %b want 1", b2.frame_done); else n_pass++;
    n_checks++; if (b2.load_ready !== 1'b1 || b2.busy !== 1'b0) $display("FAIL g0_idle ready=%b busy=%b want 1/0", b2.load_ready, b2.busy); else n_pass++;
    b2.load_data = 4'h6; b2.load_valid = 1'b1;
    tick();
    b2.load_valid = 1'b0;
    n_checks++; if (b2.busy !== 1'b1 || b2.bit_valid !== 1'b1 || b2.serial_out !== 1'b0) $display("FAIL g0_reload busy=%b bv=%b so=%b want 1/1/0", b2.busy, b2.bit_valid, b2.serial_out); else n_pass++;
    n_checks++; if (b2.frame_done !== 1'b0 || b2.bit_index !== 2'd0) $display("FAIL g0_reload_state fd=%b idx=%0d want 0/0", b2.frame_done, b2.bit_index); else n_pass++;
    repeat (4) tick();
    n_checks++; if (b2.busy !== 1'b0 || b2.frame_done !== 1'b1) $display("FAIL g0_drain busy=%b fd=%b want 0/1", b2.busy, b2.frame_done); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    b1.load_valid = 1'b0; b1.load_data = '0; b1.msb_first = 1'b0; b1.serial_ready = 1'b1;
    b2.load_valid = 1'b0; b2.load_data = '0; b2.msb_first = 1'b0; b2.serial_ready = 1'b1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/siso_frame_ctrl.md
Name: siso_frame_ctrl

Overview:
Controller that sequences the serial shift datapath. It accepts a parallel word over a valid/ready handshake and loads it into an internal shift register. It then shifts the word out one bit per accepted cycle, LSB- or MSB-first, and enforces a programmable idle gap between frames. It sits between a word-oriented producer and a bit-serial consumer that can stall.

Parameters:
WIDTH, 8, bits per frame; legal range WIDTH >= 2.
GAP_CYCLES, 2, idle cycles after each frame before the next load is accepted; legal range 0 to 255.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
load_valid  input  1  producer has a word on load_data.
load_ready  output  1  controller can accept a word; high only in IDLE.
load_data  input  WIDTH  parallel word; sampled on load handshake.
msb_first  input  1  shift order for the word; sampled on load handshake; 1 = MSB first.
serial_out  output  1  current serial bit.
bit_valid  output  1  serial_out holds a valid bit.
serial_ready  input  1  consumer accepts the bit this cycle.
bit_index  output  $clog2(WIDTH)  index (0-based, in transmit order) of the bit on serial_out.
frame_done  output  1  one-cycle pulse after the last bit of a frame is accepted.
busy  output  1  high in SHIFT or GAP.

Behaviour:
- States: IDLE, SHIFT, GAP. Internal registers: sreg[WIDTH-1:0], bit counter, gap counter.
- Reset (async, immediate) sets these values:
  - state = IDLE; sreg = 0; counters = 0.
  - serial_out = 0, bit_valid = 0, bit_index = 0, frame_done = 0, busy = 0.
  - load_ready = 1.
- Reset asserted mid-frame abandons the frame. No frame_done is produced. The first cycle after reset release is IDLE.
- Output derivations:
  - load_ready = (state == IDLE).
  - bit_valid = (state == SHIFT).
  - busy = (state != IDLE).
  - serial_out = sreg[0].
  - bit_index = bit counter.
- Load: when load_valid && load_ready at edge k, the controller does the following:
  - sreg <= load_data if msb_first = 0, else bit-reversed load_data.
  - bit counter <= 0; state <= SHIFT.
  - First bit is valid in cycle k+1.
  - load_data and msb_first are ignored at all other times.
- SHIFT:
  - Bit handshake = bit_valid && serial_ready.
  - On a handshake: sreg <= {1'b0, sreg[WIDTH-1:1]}; counter increments.
  - serial_ready = 0 stalls the controller: serial_out, bit_index and sreg hold, with no limit on stall length.
- Last bit is the handshake with counter == WIDTH-1. On that edge:
  - frame_done <= 1 for exactly one cycle.
  - Counter resets to 0.
  - state <= GAP with gap counter = 0, or state <= IDLE if GAP_CYCLES == 0.
- GAP:
  - Gap counter increments every cycle; load_ready = 0.
  - Transition to IDLE on the edge where gap counter == GAP_CYCLES-1, so GAP lasts exactly GAP_CYCLES cycles.
- Throughput: unstalled frames occupy WIDTH SHIFT cycles, then GAP_CYCLES GAP cycles, then at least 1 IDLE cycle (the load cycle).
  - Minimum load-to-load spacing is WIDTH + GAP_CYCLES + 1 cycles.
- load_valid asserted in SHIFT or GAP is not accepted. The producer holds it, and it is accepted in the first IDLE cycle.
- frame_done is a registered output, high in the cycle after the last-bit handshake, i.e. the first GAP cycle (or IDLE cycle if GAP_CYCLES = 0).
- After the last bit, sreg is all-zero, so serial_out = 0 in GAP and IDLE.

Test Plan:
- Reset then load 8'hB2, msb_first=0, serial_ready=1 -> serial_out over 8 bit_valid cycles = 0,1,0,0,1,1,0,1; bit_index 0..7; frame_done one pulse; then 2 GAP cycles with load_ready=0; then IDLE.
- Load 8'hB2, msb_first=1 -> serial_out = 1,0,1,1,0,0,1,0.
- Load 8'hA5 LSB-first; drop serial_ready for 3 cycles at bit_index 2 -> serial_out and bit_index hold at 1 and 2 during the stall; full sequence 1,0,1,0,0,1,0,1; frame spans 11 bit_valid cycles.
- load_valid held high continuously with words 8'h0F then 8'hF0 -> second word accepted exactly WIDTH+GAP_CYCLES+1 = 11 cycles after the first; no load accepted while busy.
- Assert rst at bit_index 4 of a frame -> all outputs return to reset values immediately; no frame_done; next load transmits normally.
- Build with GAP_CYCLES=0, WIDTH=4, load 4'h9 LSB-first -> bits 1,0,0,1; frame_done in the IDLE cycle; load accepted in that same cycle if load_valid=1.
